// File: rtl/adc_frame_capture_ctrl.sv
// ADS131M08 frame sequencer: one SPI word-level frame read per DRDY fall,
// packed frame out over valid/ready, with overrun and delivery counters.
module adc_frame_capture_ctrl #(
    parameter int WORDS_PER_FRAME = 10,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int CNT_W           = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          drdy_n,
    output logic                          cs_n,
    output logic                          word_req,
    input  logic                          word_valid,
    input  logic [31:0]                   word_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [32*WORDS_PER_FRAME-1:0] frame_words_packed,
    output logic                          busy,
    output logic [CNT_W-1:0]              overrun_count,
    output logic [CNT_W-1:0]              frame_count
);

    localparam int IW = $clog2(WORDS_PER_FRAME);
    localparam int FW = 32 * WORDS_PER_FRAME;
    localparam logic [IW-1:0] LAST     = IW'(WORDS_PER_FRAME - 1);
    localparam logic [3:0]    SETUP_LD = 4'(CS_SETUP_CYCLES - 1);
    localparam logic [3:0]    HOLD_LD  = 4'(CS_HOLD_CYCLES - 1);

    if (WORDS_PER_FRAME < 9 || CS_SETUP_CYCLES < 1 || CS_SETUP_CYCLES > 15 ||
        CS_HOLD_CYCLES < 1 || CS_HOLD_CYCLES > 15) begin : g_bad_param
        $fatal(1, "adc_frame_capture_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE, SETUP, REQ, WAIT, HOLD, DONE
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic [IW-1:0]  idx, idx_nxt;
    logic           sync1, sync2, sync3, drdy_evt;
    logic           store, load, drop, slot_free, ov_inc;
    logic [31:0]    shadow [WORDS_PER_FRAME];
    logic [FW-1:0]  shadow_flat;

    // sync3 is the edge-detect history; drdy_evt is registered so cs_n falls at k+3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            drdy_evt <= 1'b0;
        end else begin
            sync1    <= drdy_n;
            sync2    <= sync1;
            sync3    <= sync2;
            drdy_evt <= sync3 & ~sync2;
        end
    end

    assign slot_free = !frame_valid || frame_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        store     = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (drdy_evt && enable) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nxt = REQ;
                    idx_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (word_valid) begin
                    store = 1'b1;
                    if (idx == LAST) begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LD;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            HOLD: begin
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            DONE: begin
                state_nxt = IDLE;
                load      = slot_free;
                drop      = !slot_free;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state to keep cs_n glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            cs_n     <= 1'b1;
            word_req <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            cs_n     <= (state_nxt == IDLE) || (state_nxt == DONE);
            word_req <= (state_nxt == REQ);
            busy     <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS_PER_FRAME; i++) shadow[i] <= '0;
        end else if (store) begin
            shadow[idx] <= word_data;
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < WORDS_PER_FRAME; i++)
            shadow_flat[32*i +: 32] = shadow[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid        <= 1'b0;
            frame_words_packed <= '0;
        end else if (load) begin
            frame_valid        <= 1'b1;
            frame_words_packed <= shadow_flat;
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

    // A DRDY hit while busy and a DONE drop in one cycle are one lost sample
    assign ov_inc = (drdy_evt && state != IDLE) || drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_count <= '0;
            frame_count   <= '0;
        end else begin
            if (ov_inc && !(&overrun_count))
                overrun_count <= overrun_count + CNT_W'(1);
            if (frame_valid && frame_ready)
                frame_count <= frame_count + CNT_W'(1);
        end
    end

endmodule
